// File: rtl/mult_job_queue.sv
// Operand FIFO and job sequencer in front of the 8x8 sequential multiplier;
// issues one job at a time and holds each product for a valid/ready consumer.
//   state   | meaning
//   S_IDLE  | waiting for a queued job and a free result slot
//   S_START | operands loaded; start pulse is launched from this state
//   S_WAIT  | waiting for done (first cycle blanked) or timeout
module mult_job_queue #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                           clk,
  input  logic                           aclr_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [7:0]                     in_a,
  input  logic [7:0]                     in_b,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [15:0]                    out_product,
  output logic [7:0]                     mul_data_a,
  output logic [7:0]                     mul_data_b,
  output logic                           mul_start,
  input  logic                           mul_done,
  input  logic [15:0]                    mul_product,
  output logic [$clog2(DEPTH+1)-1:0]     level,
  output logic                           busy,
  output logic                           timeout_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT} state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [15:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_count;
  logic [7:0]    r_wait_cnt;
  logic          r_out_valid;
  logic [15:0]   r_out_product;
  logic [7:0]    r_data_a;
  logic [7:0]    r_data_b;
  logic          r_mul_start;
  logic          r_timeout_err;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_slot_free;
  logic w_capture;
  logic w_timeout;

  assign w_full      = (r_count == LW'(DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_push      = in_valid & ~w_full;
  assign w_slot_free = ~r_out_valid | out_ready;

  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    w_capture    = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty && w_slot_free) begin
          w_pop        = 1'b1;
          w_next_state = S_START;
        end
      end
      S_START: w_next_state = S_WAIT;
      S_WAIT: begin
        // wait count 0 is the blanking cycle: a done still high from the last job is ignored
        if (r_wait_cnt != 8'd0 && mul_done) begin
          w_capture    = 1'b1;
          w_next_state = S_IDLE;
        end else if (r_wait_cnt == 8'(TIMEOUT - 1)) begin
          w_timeout    = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      r_state       <= S_IDLE;
      r_wait_cnt    <= 8'd0;
      r_mul_start   <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_mul_start <= (r_state == S_START);
      if (r_state == S_START)
        r_wait_cnt <= 8'd0;
      else if (r_state == S_WAIT)
        r_wait_cnt <= r_wait_cnt + 8'd1;
      if (w_timeout)
        r_timeout_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= 16'd0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= {in_a, in_b};
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + LW'(1);
        2'b01:   r_count <= r_count - LW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      r_data_a      <= 8'd0;
      r_data_b      <= 8'd0;
      r_out_valid   <= 1'b0;
      r_out_product <= 16'd0;
    end else begin
      if (w_pop)
        {r_data_a, r_data_b} <= r_mem[r_rd_ptr];
      if (w_capture) begin
        r_out_valid   <= 1'b1;
        r_out_product <= mul_product;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready    = ~w_full;
  assign out_valid   = r_out_valid;
  assign out_product = r_out_product;
  assign mul_data_a  = r_data_a;
  assign mul_data_b  = r_data_b;
  assign mul_start   = r_mul_start;
  assign level       = r_count;
  assign busy        = (r_state != S_IDLE);
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_mult_job_queue.sv
// Bench for mult_job_queue: behavioural multiplier, product queue model and
// per-scenario tasks with inline comparisons.
module tb_mult_job_queue;

  logic        clk = 1'b0;
  logic        aclr_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_product;
  logic [7:0]  mul_data_a;
  logic [7:0]  mul_data_b;
  logic        mul_start;
  logic        mul_done;
  logic [15:0] mul_product;
  logic [2:0]  level;
  logic        busy;
  logic        timeout_err;

  int n_pass  = 0;
  int n_total = 0;
  int n_starts = 0;
  logic [15:0] exp_q [$];

  // multiplier model knobs
  int   lat     = 4;
  logic done_en = 1'b1;
  logic stuck   = 1'b0;
  int   m_cnt;
  logic [15:0] m_a, m_b;

  mult_job_queue #(.DEPTH(4), .TIMEOUT(15)) dut (
    .clk(clk), .aclr_n(aclr_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_product(out_product),
    .mul_data_a(mul_data_a), .mul_data_b(mul_data_b), .mul_start(mul_start),
    .mul_done(mul_done), .mul_product(mul_product),
    .level(level), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // done rises lat cycles after start is sampled; in stuck mode it stays high until the next start
  always @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      m_cnt <= 0; mul_done <= 1'b0; mul_product <= 16'd0; m_a <= 16'd0; m_b <= 16'd0;
    end else if (mul_start) begin
      m_cnt <= done_en ? lat : 0;
      m_a <= {8'd0, mul_data_a};
      m_b <= {8'd0, mul_data_b};
      mul_done <= 1'b0;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        mul_done <= 1'b1;
        mul_product <= m_a * m_b;
      end
    end else if (!stuck) begin
      mul_done <= 1'b0;
    end
  end

  always @(posedge clk) if (mul_start) n_starts <= n_starts + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_job(input logic [7:0] a, input logic [7:0] b);
    int w = 0;
    in_a = a; in_b = b; in_valid = 1'b1;
    while (!in_ready && w < 100) begin @(negedge clk); w++; end
    if (!in_ready) begin
      n_total++;
      $display("FAIL push_ready_wait: in_ready got %b required 1 within 100 cycles", in_ready);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      exp_q.push_back(16'(a) * 16'(b));
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic collect(output logic [15:0] prod, output logic ok);
    int w = 0;
    while (!out_valid && w < 100) begin @(negedge clk); w++; end
    ok = out_valid;
    prod = out_product;
    if (ok) begin
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    aclr_n = 1'b0; in_valid = 1'b0; in_a = 8'd0; in_b = 8'd0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_total++;
    if ({out_valid, mul_start, busy, timeout_err, in_ready} !== 5'b00001)
      $display("FAIL reset_flags: got %b required 00001", {out_valid, mul_start, busy, timeout_err, in_ready});
    else n_pass++;
    n_total++;
    if ({out_product, mul_data_a, mul_data_b, level} !== 35'd0)
      $display("FAIL reset_data: got prod=%h a=%h b=%h level=%0d required all 0", out_product, mul_data_a, mul_data_b, level);
    else n_pass++;
    aclr_n = 1'b1;
    repeat (2) @(negedge clk);
    n_total++;
    if ({busy, mul_start, level} !== 5'd0)
      $display("FAIL reset_idle_after_release: got busy=%b start=%b level=%0d required 0", busy, mul_start, level);
    else n_pass++;
  endtask

  task automatic test_single();
    logic [15:0] p; logic ok; int s0;
    s0 = n_starts;
    in_a = 8'h0F; in_b = 8'h0F; in_valid = 1'b1;
    @(posedge clk);
    exp_q.push_back(16'h00E1);
    @(negedge clk);
    in_valid = 1'b0;
    n_total++;
    if (level !== 3'd1 || mul_start !== 1'b0)
      $display("FAIL single_after_push: got level=%0d start=%b required level=1 start=0", level, mul_start);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if ({mul_start, busy, mul_data_a, mul_data_b, level} !== {1'b0, 1'b1, 8'h0F, 8'h0F, 3'd0})
      $display("FAIL single_pop: got start=%b busy=%b a=%h b=%h level=%0d required 0 1 0f 0f 0",
               mul_start, busy, mul_data_a, mul_data_b, level);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (mul_start !== 1'b1)
      $display("FAIL single_start_timing: got mul_start=%b required 1 two cycles after push", mul_start);
    else n_pass++;
    collect(p, ok);
    n_total++;
    if (!ok || p !== exp_q[0])
      $display("FAIL single_product: got valid=%b product=%h required 1 %h", ok, p, exp_q[0]);
    else n_pass++;
    void'(exp_q.pop_front());
    n_total++;
    if ((n_starts - s0) !== 1 || level !== 3'd0)
      $display("FAIL single_start_count: got pulses=%0d level=%0d required 1 0", n_starts - s0, level);
    else n_pass++;
  endtask

  task automatic test_max_zero();
    logic [15:0] p; logic ok; int bad = 0; int w;
    push_job(8'hFF, 8'hFF);
    push_job(8'h00, 8'hA5);
    w = 0;
    while (!out_valid && w < 100) begin
      if (busy && {mul_data_a, mul_data_b} !== 16'hFFFF) bad++;
      @(negedge clk); w++;
    end
    collect(p, ok);
    n_total++;
    if (!ok || p !== exp_q[0])
      $display("FAIL max_product: got valid=%b product=%h required 1 %h", ok, p, exp_q[0]);
    else n_pass++;
    void'(exp_q.pop_front());
    w = 0;
    while (!out_valid && w < 100) begin
      if (busy && {mul_data_a, mul_data_b} !== 16'h00A5) bad++;
      @(negedge clk); w++;
    end
    collect(p, ok);
    n_total++;
    if (!ok || p !== exp_q[0])
      $display("FAIL zero_product: got valid=%b product=%h required 1 %h", ok, p, exp_q[0]);
    else n_pass++;
    void'(exp_q.pop_front());
    n_total++;
    if (bad !== 0)
      $display("FAIL operand_stability: got %0d unstable busy cycles required 0", bad);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [15:0] p; logic ok;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_job(8'(8'h10 + i), 8'(3 * i + 1));
    repeat (20) @(negedge clk);
    n_total++;
    if ({out_valid, level, in_ready} !== {1'b1, 3'd4, 1'b0})
      $display("FAIL bp_full: got valid=%b level=%0d in_ready=%b required 1 4 0", out_valid, level, in_ready);
    else n_pass++;
    in_a = 8'h55; in_b = 8'h55; in_valid = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    n_total++;
    if (level !== 3'd4 || busy !== 1'b0)
      $display("FAIL bp_no_push_no_pop: got level=%0d busy=%b required 4 0", level, busy);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      collect(p, ok);
      n_total++;
      if (!ok || p !== exp_q[0])
        $display("FAIL bp_result_%0d: got valid=%b product=%h required 1 %h", i, ok, p, exp_q[0]);
      else n_pass++;
      void'(exp_q.pop_front());
    end
    repeat (30) @(negedge clk);
    n_total++;
    if ({out_valid, busy, level} !== 5'd0)
      $display("FAIL bp_no_extra: got valid=%b busy=%b level=%0d required 0 0 0", out_valid, busy, level);
    else n_pass++;
  endtask

  task automatic test_stuck_done();
    logic [15:0] p; logic ok;
    stuck = 1'b1;
    push_job(8'd3, 8'd5);
    collect(p, ok);
    n_total++;
    if (!ok || p !== exp_q[0])
      $display("FAIL stuck_first: got valid=%b product=%h required 1 %h", ok, p, exp_q[0]);
    else n_pass++;
    void'(exp_q.pop_front());
    push_job(8'd7, 8'd9);
    collect(p, ok);
    n_total++;
    if (!ok || p !== exp_q[0])
      $display("FAIL stuck_blanking: got valid=%b product=%h required 1 %h", ok, p, exp_q[0]);
    else n_pass++;
    void'(exp_q.pop_front());
    stuck = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_timeout();
    logic [15:0] p; logic ok; int w;
    done_en = 1'b0;
    push_job(8'h12, 8'h34);
    void'(exp_q.pop_back());
    w = 0;
    while (!mul_start && w < 20) begin @(negedge clk); w++; end
    w = 0;
    while (!timeout_err && w < 40) begin @(negedge clk); w++; end
    n_total++;
    if (w !== 15)
      $display("FAIL timeout_cycles: got %0d wait cycles required 15", w);
    else n_pass++;
    n_total++;
    if ({out_valid, busy, timeout_err} !== 3'b001)
      $display("FAIL timeout_state: got valid=%b busy=%b err=%b required 0 0 1", out_valid, busy, timeout_err);
    else n_pass++;
    done_en = 1'b1;
    push_job(8'd2, 8'd3);
    collect(p, ok);
    n_total++;
    if (!ok || p !== exp_q[0] || timeout_err !== 1'b1)
      $display("FAIL timeout_recover: got valid=%b product=%h err=%b required 1 %h 1", ok, p, timeout_err, exp_q[0]);
    else n_pass++;
    void'(exp_q.pop_front());
  endtask

  task automatic test_async_reset();
    logic [15:0] p; logic ok; int s0;
    push_job(8'h11, 8'h22);
    push_job(8'h33, 8'h44);
    push_job(8'h55, 8'h66);
    n_total++;
    if ({mul_start, busy, level} !== {1'b1, 1'b1, 3'd2})
      $display("FAIL arst_setup: got start=%b busy=%b level=%0d required 1 1 2", mul_start, busy, level);
    else n_pass++;
    #2 aclr_n = 1'b0;
    #1;
    n_total++;
    if ({out_valid, mul_start, busy, timeout_err, in_ready, level, mul_data_a, mul_data_b, out_product}
        !== {5'b00001, 3'd0, 32'd0})
      $display("FAIL arst_immediate: got valid=%b start=%b busy=%b err=%b rdy=%b level=%0d a=%h b=%h p=%h required reset values",
               out_valid, mul_start, busy, timeout_err, in_ready, level, mul_data_a, mul_data_b, out_product);
    else n_pass++;
    exp_q.delete();
    @(negedge clk);
    aclr_n = 1'b1;
    s0 = n_starts;
    repeat (12) @(negedge clk);
    n_total++;
    if ((n_starts - s0) !== 0 || {level, busy, out_valid} !== 5'd0)
      $display("FAIL arst_quiet: got pulses=%0d level=%0d busy=%b valid=%b required 0 0 0 0",
               n_starts - s0, level, busy, out_valid);
    else n_pass++;
    push_job(8'h0A, 8'h0B);
    collect(p, ok);
    n_total++;
    if (!ok || p !== exp_q[0])
      $display("FAIL arst_after_job: got valid=%b product=%h required 1 %h", ok, p, exp_q[0]);
    else n_pass++;
    void'(exp_q.pop_front());
  endtask

  task automatic test_random();
    logic [15:0] p; logic ok; int n;
    for (int it = 0; it < 8; it++) begin
      lat = $urandom_range(1, 8);
      n = $urandom_range(1, 4);
      for (int j = 0; j < n; j++) push_job(8'($urandom), 8'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      for (int j = 0; j < n; j++) begin
        collect(p, ok);
        n_total++;
        if (!ok || p !== exp_q[0])
          $display("FAIL random_%0d_%0d: got valid=%b product=%h required 1 %h", it, j, ok, p, exp_q[0]);
        else n_pass++;
        void'(exp_q.pop_front());
      end
    end
    lat = 4;
  endtask

  initial begin
    test_reset();
    test_single();
    test_max_zero();
    test_backpressure();
    test_stuck_done();
    test_timeout();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
